// File: rtl/fractal_stream_generator.sv
// Streams Julia/Mandelbrot escape-time iteration counts in raster order, one pixel
// per handshake, using a single fixed-point iteration per clock.
module fractal_stream_generator #(
   parameter int WORD_W = 32,
   parameter int FRAC_W = 28,
   parameter int DATA_W = 8
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     enable,
   input  logic                     mode,
   input  logic [15:0]              width,
   input  logic [15:0]              height,
   input  logic [DATA_W-1:0]        max_iter,
   input  logic signed [WORD_W-1:0] cr,
   input  logic signed [WORD_W-1:0] ci,
   input  logic signed [WORD_W-1:0] dx,
   input  logic signed [WORD_W-1:0] dy,
   input  logic signed [WORD_W-1:0] x0,
   input  logic signed [WORD_W-1:0] y0,
   output logic [DATA_W-1:0]        m_data,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic                     m_frame_start,
   output logic                     m_line_end,
   output logic                     busy
);

   // state  | meaning
   // IDLE   | waiting for enable and a non-empty frame size
   // INIT   | latch frame configuration, load pixel (0,0)
   // ITER   | one z <- z^2 + c step per cycle until escape or iteration limit
   // EMIT   | present result, hold until accepted, then advance pixel
   typedef enum logic [1:0] {S_IDLE, S_INIT, S_ITER, S_EMIT} state_t;

   localparam int PW = 2 * WORD_W;
   localparam logic [WORD_W+1:0] ESC_LIM = (WORD_W+2)'(1) << (FRAC_W + 2);

   state_t state_q, state_d;
   logic   rdy_q;

   logic                     mode_q, mode_d;
   logic [15:0]              width_q, width_d, height_q, height_d;
   logic [15:0]              col_q, col_d, row_q, row_d;
   logic [DATA_W-1:0]        max_iter_q, max_iter_d, k_q, k_d, m_data_q, m_data_d;
   logic signed [WORD_W-1:0] cr_q, cr_d, ci_q, ci_d, dx_q, dx_d, dy_q, dy_d;
   logic signed [WORD_W-1:0] x0_q, x0_d, y0_q, y0_d;
   logic signed [WORD_W-1:0] re_q, re_d, im_q, im_d, zr_q, zr_d, zi_q, zi_d;

   logic signed [PW-1:0]     zr_x, zi_x, p_rr, p_ii, p_ri, s_rr, s_ii, s_ri;
   logic signed [WORD_W-1:0] sq_rr, sq_ii, sq_ri, c_r, c_i, zr_nx, zi_nx;
   logic [WORD_W:0]          mag_rr, mag_ii;
   logic [WORD_W+1:0]        esc_sum;
   logic                     escaped;

   logic                     last_col, last_row;
   logic [15:0]              col_adv, row_adv;
   logic signed [WORD_W-1:0] re_adv, im_adv;

   always_comb begin
      zr_x  = {{WORD_W{zr_q[WORD_W-1]}}, zr_q};
      zi_x  = {{WORD_W{zi_q[WORD_W-1]}}, zi_q};
      p_rr  = zr_x * zr_x;
      p_ii  = zi_x * zi_x;
      p_ri  = zr_x * zi_x;
      s_rr  = p_rr >>> FRAC_W;
      s_ii  = p_ii >>> FRAC_W;
      s_ri  = p_ri >>> FRAC_W;
      sq_rr = s_rr[WORD_W-1:0];
      sq_ii = s_ii[WORD_W-1:0];
      sq_ri = s_ri[WORD_W-1:0];
      // Squares are non-negative; saturating them keeps the escape sum exact
      // below the limit even when the wrapped WORD_W square would go negative.
      mag_rr  = (|s_rr[PW-1:WORD_W+1]) ? '1 : s_rr[WORD_W:0];
      mag_ii  = (|s_ii[PW-1:WORD_W+1]) ? '1 : s_ii[WORD_W:0];
      esc_sum = {1'b0, mag_rr} + {1'b0, mag_ii};
      escaped = esc_sum > ESC_LIM;
      c_r     = mode_q ? re_q : cr_q;
      c_i     = mode_q ? im_q : ci_q;
      zr_nx   = sq_rr - sq_ii + c_r;
      zi_nx   = (sq_ri <<< 1) + c_i;
   end

   always_comb begin
      last_col = (col_q == width_q - 16'd1);
      last_row = (row_q == height_q - 16'd1);
      if (last_col) begin
         col_adv = 16'd0;
         row_adv = row_q + 16'd1;
         re_adv  = -x0_q;
         im_adv  = im_q - dy_q;
      end else begin
         col_adv = col_q + 16'd1;
         row_adv = row_q;
         re_adv  = re_q + dx_q;
         im_adv  = im_q;
      end
   end

   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      width_d    = width_q;
      height_d   = height_q;
      max_iter_d = max_iter_q;
      cr_d       = cr_q;
      ci_d       = ci_q;
      dx_d       = dx_q;
      dy_d       = dy_q;
      x0_d       = x0_q;
      y0_d       = y0_q;
      col_d      = col_q;
      row_d      = row_q;
      re_d       = re_q;
      im_d       = im_q;
      zr_d       = zr_q;
      zi_d       = zi_q;
      k_d        = k_q;
      m_data_d   = m_data_q;
      case (state_q)
         S_IDLE: begin
            if (rdy_q && enable && (width != 16'd0) && (height != 16'd0))
               state_d = S_INIT;
         end
         S_INIT: begin
            mode_d     = mode;
            width_d    = width;
            height_d   = height;
            max_iter_d = max_iter;
            cr_d       = cr;
            ci_d       = ci;
            dx_d       = dx;
            dy_d       = dy;
            x0_d       = x0;
            y0_d       = y0;
            col_d      = 16'd0;
            row_d      = 16'd0;
            re_d       = -x0;
            im_d       = y0;
            zr_d       = mode ? '0 : -x0;
            zi_d       = mode ? '0 : y0;
            k_d        = '0;
            // A back-to-back frame may arrive here with an empty size.
            state_d    = ((width == 16'd0) || (height == 16'd0)) ? S_IDLE : S_ITER;
         end
         S_ITER: begin
            if (escaped) begin
               m_data_d = k_q;
               state_d  = S_EMIT;
            end else if (k_q == max_iter_q) begin
               m_data_d = max_iter_q;
               state_d  = S_EMIT;
            end else begin
               zr_d = zr_nx;
               zi_d = zi_nx;
               k_d  = k_q + 1'b1;
            end
         end
         S_EMIT: begin
            if (m_ready) begin
               if (last_col && last_row) begin
                  state_d = enable ? S_INIT : S_IDLE;
               end else begin
                  col_d   = col_adv;
                  row_d   = row_adv;
                  re_d    = re_adv;
                  im_d    = im_adv;
                  zr_d    = mode_q ? '0 : re_adv;
                  zi_d    = mode_q ? '0 : im_adv;
                  k_d     = '0;
                  state_d = S_ITER;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= S_IDLE;
         rdy_q      <= 1'b0;
         mode_q     <= 1'b0;
         width_q    <= '0;
         height_q   <= '0;
         max_iter_q <= '0;
         cr_q       <= '0;
         ci_q       <= '0;
         dx_q       <= '0;
         dy_q       <= '0;
         x0_q       <= '0;
         y0_q       <= '0;
         col_q      <= '0;
         row_q      <= '0;
         re_q       <= '0;
         im_q       <= '0;
         zr_q       <= '0;
         zi_q       <= '0;
         k_q        <= '0;
         m_data_q   <= '0;
      end else begin
         state_q    <= state_d;
         rdy_q      <= 1'b1;
         mode_q     <= mode_d;
         width_q    <= width_d;
         height_q   <= height_d;
         max_iter_q <= max_iter_d;
         cr_q       <= cr_d;
         ci_q       <= ci_d;
         dx_q       <= dx_d;
         dy_q       <= dy_d;
         x0_q       <= x0_d;
         y0_q       <= y0_d;
         col_q      <= col_d;
         row_q      <= row_d;
         re_q       <= re_d;
         im_q       <= im_d;
         zr_q       <= zr_d;
         zi_q       <= zi_d;
         k_q        <= k_d;
         m_data_q   <= m_data_d;
      end
   end

   assign m_valid       = (state_q == S_EMIT);
   assign m_data        = m_data_q;
   assign m_frame_start = m_valid && (col_q == 16'd0) && (row_q == 16'd0);
   assign m_line_end    = m_valid && last_col;
   assign busy          = (state_q != S_IDLE);

endmodule
